// File: rtl/text_cell_scanner.sv
// text_cell_scanner: turns the raw VGA scan position into text-cell coordinates,
// a linear text-buffer address, a per-cell fetch strobe, a frame strobe and a
// blinking cursor flag. Cell size, grid size and scroll are all parametrised;
// scroll inputs are captured only at the frame end so the picture never tears.
module text_cell_scanner #(
    parameter int HSZ      = 10,
    parameter int VSZ      = 9,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CELL_W   = 8,
    parameter int CELL_H   = 8,
    parameter int COLS     = 80,
    parameter int ROWS     = 60,
    parameter int AW       = 13
) (
    input  logic                        i_pix_clk,
    input  logic                        i_rst,
    input  logic [HSZ-1:0]              i_scan_column,
    input  logic [VSZ-1:0]              i_scan_row,
    input  logic [$clog2(ROWS)-1:0]     i_scroll_row,
    input  logic [$clog2(CELL_H)-1:0]   i_scroll_fine,
    input  logic                        i_cursor_en,
    input  logic [$clog2(COLS)-1:0]     i_cursor_col,
    input  logic [$clog2(ROWS)-1:0]     i_cursor_row,
    input  logic [5:0]                  i_blink_frames,
    output logic [$clog2(CELL_W)-1:0]   o_glyph_col,
    output logic [$clog2(CELL_H)-1:0]   o_glyph_row,
    output logic [$clog2(COLS)-1:0]     o_cell_col,
    output logic [$clog2(ROWS)-1:0]     o_cell_row,
    output logic [AW-1:0]               o_cell_addr,
    output logic                        o_fetch_stb,
    output logic                        o_cursor_on,
    output logic                        o_frame_stb
);

    localparam int GCW = $clog2(CELL_W);
    localparam int GRW = $clog2(CELL_H);
    localparam int CCW = $clog2(COLS);
    localparam int CRW = $clog2(ROWS);

    // Widened compare constants so the active-area test cannot overflow.
    localparam logic [HSZ:0]   H_ACT_EXT = (HSZ+1)'(H_ACTIVE);
    localparam logic [VSZ:0]   V_ACT_EXT = (VSZ+1)'(V_ACTIVE);
    localparam logic [HSZ-1:0] H_LAST    = HSZ'(H_ACTIVE - 1);
    localparam logic [VSZ-1:0] V_LAST    = VSZ'(V_ACTIVE - 1);
    localparam logic [GCW-1:0] GC_LAST   = GCW'(CELL_W - 1);
    localparam logic [GRW-1:0] GR_LAST   = GRW'(CELL_H - 1);
    localparam logic [CRW-1:0] CR_LAST   = CRW'(ROWS - 1);
    localparam logic [AW-1:0]  ROW_STEP  = AW'(COLS);

    // Vertical state for the line currently being scanned.
    logic [GRW-1:0] r_glyph_row;
    logic [CRW-1:0] r_cell_row;
    logic [AW-1:0]  r_line_base;

    // Blink state: frames elapsed in the current half-period, and visibility.
    logic [5:0]     r_blink_cnt;
    logic           r_phase;

    logic           w_active;
    logic           w_col_zero;
    logic           w_line_end;
    logic           w_frame_end;
    logic [GCW-1:0] w_gc_nxt;
    logic [CCW-1:0] w_cc_nxt;
    logic [AW-1:0]  w_addr_nxt;

    assign w_active    = ({1'b0, i_scan_column} < H_ACT_EXT) &&
                         ({1'b0, i_scan_row} < V_ACT_EXT);
    assign w_col_zero  = (i_scan_column == '0);
    assign w_line_end  = (i_scan_column == H_LAST) &&
                         ({1'b0, i_scan_row} < {1'b0, V_LAST});
    assign w_frame_end = (i_scan_column == H_LAST) && (i_scan_row == V_LAST);

    // Horizontal position of the pixel being sampled, derived by incrementing
    // the previous pixel's registered coordinates (column 0 restarts the line).
    always_comb begin
        w_gc_nxt   = o_glyph_col;
        w_cc_nxt   = o_cell_col;
        w_addr_nxt = o_cell_addr;
        if (w_col_zero) begin
            w_gc_nxt   = '0;
            w_cc_nxt   = '0;
            w_addr_nxt = r_line_base;
        end else if (o_glyph_col == GC_LAST) begin
            w_gc_nxt   = '0;
            w_cc_nxt   = o_cell_col + 1'b1;
            w_addr_nxt = o_cell_addr + 1'b1;
        end else begin
            w_gc_nxt   = o_glyph_col + 1'b1;
        end
    end

    // Registered per-pixel outputs; geometry holds outside the active area.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            o_glyph_col <= '0;
            o_glyph_row <= '0;
            o_cell_col  <= '0;
            o_cell_row  <= '0;
            o_cell_addr <= '0;
            o_fetch_stb <= 1'b0;
            o_cursor_on <= 1'b0;
            o_frame_stb <= 1'b0;
        end else begin
            o_fetch_stb <= 1'b0;
            o_cursor_on <= 1'b0;
            o_frame_stb <= w_frame_end;
            if (w_active) begin
                o_glyph_col <= w_gc_nxt;
                o_cell_col  <= w_cc_nxt;
                o_cell_addr <= w_addr_nxt;
                o_glyph_row <= r_glyph_row;
                o_cell_row  <= r_cell_row;
                o_fetch_stb <= (w_gc_nxt == '0);
                o_cursor_on <= i_cursor_en && r_phase &&
                               (w_cc_nxt == i_cursor_col) &&
                               (r_cell_row == i_cursor_row);
            end
        end
    end

    // Vertical tracking: step at each active line end, reload scroll at frame end.
    // The frame-end reload is the only place a multiply appears.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_glyph_row <= '0;
            r_cell_row  <= '0;
            r_line_base <= '0;
        end else if (w_frame_end) begin
            r_glyph_row <= i_scroll_fine;
            r_cell_row  <= i_scroll_row;
            r_line_base <= AW'(i_scroll_row) * ROW_STEP;
        end else if (w_line_end) begin
            if (r_glyph_row == GR_LAST) begin
                r_glyph_row <= '0;
                if (r_cell_row == CR_LAST) begin
                    r_cell_row  <= '0;
                    r_line_base <= '0;
                end else begin
                    r_cell_row  <= r_cell_row + 1'b1;
                    r_line_base <= r_line_base + ROW_STEP;
                end
            end else begin
                r_glyph_row <= r_glyph_row + 1'b1;
            end
        end
    end

    // Cursor blink: count frame ends, toggle visibility every i_blink_frames
    // frames; a zero period pins the cursor visible.
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (i_blink_frames == '0) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_frame_end) begin
            if (r_blink_cnt == (i_blink_frames - 6'd1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 6'd1;
            end
        end
    end

endmodule
